// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data,
// aligns/extends load results and drives the regfile write port.
module wb_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_res,
    input  logic [2:0]  ms_load_op,
    input  logic [31:0] ms_rt_val,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [3:0]  rf_wbytes,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_valid,
    output logic [4:0]  ws_fwd_dest,
    output logic        ws_fwd_blocked,
    output logic [31:0] debug_wb_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LB   = 3'd1;
    localparam logic [2:0] OP_LBU  = 3'd2;
    localparam logic [2:0] OP_LH   = 3'd3;
    localparam logic [2:0] OP_LHU  = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_LWL  = 3'd6;
    localparam logic [2:0] OP_LWR  = 3'd7;

    state_t      state, state_nxt;
    logic        ws_valid;
    logic        ws_ready_go;
    logic        accept;

    logic [31:0] ws_pc;
    logic        ws_gr_we;
    logic [4:0]  ws_dest;
    logic [31:0] ws_res;
    logic [2:0]  ws_load_op;
    logic [31:0] ws_rt_val;

    logic [1:0]  lane_a;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] shifted;
    logic [3:0]  lane_mask;
    logic [31:0] bit_mask;
    logic [31:0] wdata_raw;
    logic [3:0]  wbytes_raw;

    // Control / next state
    always_comb begin
        ws_valid    = (state != S_IDLE);
        ws_ready_go = (state == S_RUN) || ((state == S_WAIT) && data_data_ok);
        ws_allowin  = !ws_valid || ws_ready_go;
        accept      = ms_to_ws_valid && ws_allowin;
        state_nxt   = state;
        if (accept) begin
            state_nxt = (ms_load_op != OP_NONE) ? S_WAIT : S_RUN;
        end else if (ws_ready_go) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            ws_pc      <= '0;
            ws_gr_we   <= 1'b0;
            ws_dest    <= '0;
            ws_res     <= '0;
            ws_load_op <= '0;
            ws_rt_val  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ws_pc      <= ms_pc;
                ws_gr_we   <= ms_gr_we;
                ws_dest    <= ms_dest;
                ws_res     <= ms_res;
                ws_load_op <= ms_load_op;
                ws_rt_val  <= ms_rt_val;
            end
        end
    end

    // Load alignment and LWL/LWR lane merge
    always_comb begin
        lane_a     = ws_res[1:0];
        byte_v     = 8'(data_rdata >> {lane_a, 3'b000});
        half_v     = 16'(data_rdata >> {lane_a[1], 4'b0000});
        shifted    = data_rdata;
        lane_mask  = 4'b1111;
        wdata_raw  = ws_res;
        wbytes_raw = 4'b1111;
        case (ws_load_op)
            OP_LWL: begin
                shifted = data_rdata << {~lane_a, 3'b000};
                case (lane_a)
                    2'd0:    lane_mask = 4'b1000;
                    2'd1:    lane_mask = 4'b1100;
                    2'd2:    lane_mask = 4'b1110;
                    default: lane_mask = 4'b1111;
                endcase
            end
            OP_LWR: begin
                shifted = data_rdata >> {lane_a, 3'b000};
                case (lane_a)
                    2'd0:    lane_mask = 4'b1111;
                    2'd1:    lane_mask = 4'b0111;
                    2'd2:    lane_mask = 4'b0011;
                    default: lane_mask = 4'b0001;
                endcase
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
        case (ws_load_op)
            OP_LB:  wdata_raw = {{24{byte_v[7]}}, byte_v};
            OP_LBU: wdata_raw = {24'd0, byte_v};
            OP_LH:  wdata_raw = {{16{half_v[15]}}, half_v};
            OP_LHU: wdata_raw = {16'd0, half_v};
            OP_LW:  wdata_raw = data_rdata;
            OP_LWL, OP_LWR: begin
                wdata_raw  = (shifted & bit_mask) | (ws_rt_val & ~bit_mask);
                wbytes_raw = lane_mask;
            end
            default: wdata_raw = ws_res;
        endcase
    end

    // Write port and hazard exports; write-port fields read 0 when idle
    always_comb begin
        rf_we          = ws_valid && ws_gr_we && ws_ready_go && (ws_dest != 5'd0);
        rf_waddr       = rf_we ? ws_dest    : '0;
        rf_wbytes      = rf_we ? wbytes_raw : '0;
        rf_wdata       = rf_we ? wdata_raw  : '0;
        debug_wb_pc    = rf_we ? ws_pc      : '0;
        ws_fwd_valid   = ws_valid && ws_gr_we && (ws_dest != 5'd0);
        ws_fwd_dest    = ws_fwd_valid ? ws_dest : '0;
        ws_fwd_blocked = ws_fwd_valid && (state == S_WAIT) && !data_data_ok;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes queued at issue time,
// popped and compared whenever the DUT asserts rf_we.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_res;
    logic [2:0]  ms_load_op;
    logic [31:0] ms_rt_val;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [3:0]  rf_wbytes;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic        ws_fwd_blocked;
    logic [31:0] debug_wb_pc;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  waddr;
        logic [3:0]  wbytes;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    wb_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ws_allowin     (ws_allowin),
        .ms_pc          (ms_pc),
        .ms_gr_we       (ms_gr_we),
        .ms_dest        (ms_dest),
        .ms_res         (ms_res),
        .ms_load_op     (ms_load_op),
        .ms_rt_val      (ms_rt_val),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wbytes      (rf_wbytes),
        .rf_wdata       (rf_wdata),
        .ws_fwd_valid   (ws_fwd_valid),
        .ws_fwd_dest    (ws_fwd_dest),
        .ws_fwd_blocked (ws_fwd_blocked),
        .debug_wb_pc    (debug_wb_pc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result written lane by lane, independent of the RTL's shift/mask form
    function automatic exp_t model(input logic [4:0] dest, input logic [31:0] pc,
                                   input logic [31:0] res, input logic [2:0] op,
                                   input logic [31:0] rt, input logic [31:0] rd);
        exp_t e;
        logic [7:0]  b;
        logic [15:0] h;
        e.waddr  = dest;
        e.pc     = pc;
        e.wbytes = 4'hF;
        case (res[1:0])
            2'd0: b = rd[7:0];
            2'd1: b = rd[15:8];
            2'd2: b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = res[1] ? rd[31:16] : rd[15:0];
        case (op)
            3'd1: e.wdata = {{24{b[7]}}, b};
            3'd2: e.wdata = {24'h0, b};
            3'd3: e.wdata = {{16{h[15]}}, h};
            3'd4: e.wdata = {16'h0, h};
            3'd5: e.wdata = rd;
            3'd6: case (res[1:0])
                2'd0: begin e.wbytes = 4'b1000; e.wdata = {rd[7:0],  rt[23:0]}; end
                2'd1: begin e.wbytes = 4'b1100; e.wdata = {rd[15:0], rt[15:0]}; end
                2'd2: begin e.wbytes = 4'b1110; e.wdata = {rd[23:0], rt[7:0]};  end
                default: begin e.wbytes = 4'b1111; e.wdata = rd; end
            endcase
            3'd7: case (res[1:0])
                2'd0: begin e.wbytes = 4'b1111; e.wdata = rd; end
                2'd1: begin e.wbytes = 4'b0111; e.wdata = {rt[31:24], rd[31:8]};  end
                2'd2: begin e.wbytes = 4'b0011; e.wdata = {rt[31:16], rd[31:16]}; end
                default: begin e.wbytes = 4'b0001; e.wdata = {rt[31:8], rd[31:24]}; end
            endcase
            default: e.wdata = res;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (resetn === 1'b1 && rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_waddr",  rf_waddr,    e.waddr);
                check("sb_wbytes", rf_wbytes,   e.wbytes);
                check("sb_wdata",  rf_wdata,    e.wdata);
                check("sb_pc",     debug_wb_pc, e.pc);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the accept edge
    task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                         input logic [31:0] res, input logic [2:0] op,
                         input logic [31:0] rt, input logic [31:0] rd, input bit push);
        ms_to_ws_valid = 1'b1;
        ms_pc      = pc;
        ms_gr_we   = we;
        ms_dest    = dest;
        ms_res     = res;
        ms_load_op = op;
        ms_rt_val  = rt;
        if (push && we && dest != 5'd0) sb.push_back(model(dest, pc, res, op, rt, rd));
        @(negedge clk);
        check("allowin", ws_allowin, 1);
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic load_resp(input int waits, input logic [4:0] dest, input logic [31:0] rd,
                             input logic [31:0] exp_d, input logic [3:0] exp_b);
        repeat (waits) begin
            @(negedge clk);
            check("wait_allowin", ws_allowin, 0);
            check("wait_blocked", ws_fwd_blocked, 1);
            check("wait_fwd_dest", ws_fwd_dest, dest);
            check("wait_no_we", rf_we, 0);
            @(posedge clk); #1;
        end
        data_data_ok = 1'b1;
        data_rdata   = rd;
        @(negedge clk);
        check("ld_we", rf_we, 1);
        check("ld_wdata", rf_wdata, exp_d);
        check("ld_wbytes", rf_wbytes, exp_b);
        check("ld_unblocked", ws_fwd_blocked, 0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        data_rdata   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_allowin"}, ws_allowin, 1);
        check({tag, "_we"},      rf_we, 0);
        check({tag, "_waddr"},   rf_waddr, 0);
        check({tag, "_wbytes"},  rf_wbytes, 0);
        check({tag, "_wdata"},   rf_wdata, 0);
        check({tag, "_fwdv"},    ws_fwd_valid, 0);
        check({tag, "_fwdd"},    ws_fwd_dest, 0);
        check({tag, "_blk"},     ws_fwd_blocked, 0);
        check({tag, "_pc"},      debug_wb_pc, 0);
    endtask

    initial begin
        resetn = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_res = '0;
        ms_load_op = '0; ms_rt_val = '0;
        data_data_ok = 1'b0; data_rdata = '0;
        @(negedge clk);
        check_reset_outputs("rst");
        idle(2);
        resetn = 1'b1;
        idle(1);

        // 1: single ALU op
        issue(32'hBFC0_0000, 1'b1, 5'd3, 32'h1234_5678, 3'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("add_we", rf_we, 1);
        check("add_wdata", rf_wdata, 32'h1234_5678);
        check("add_pc", debug_wb_pc, 32'hBFC0_0000);
        idle(1);

        // 2: LB with three wait cycles
        issue(32'hBFC0_0004, 1'b1, 5'd9, 32'h1000_0001, 3'd1, 32'h0, 32'h0000_80FF, 1'b1);
        load_resp(3, 5'd9, 32'h0000_80FF, 32'hFFFF_FF80, 4'hF);

        // 3: LWL / LWR merges
        issue(32'hBFC0_0008, 1'b1, 5'd4, 32'h2000_0001, 3'd6, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
        load_resp(1, 5'd4, 32'h1122_3344, 32'h3344_CCDD, 4'b1100);
        issue(32'hBFC0_000C, 1'b1, 5'd5, 32'h2000_0002, 3'd7, 32'hAABB_CCDD, 32'h1122_3344, 1'b1);
        load_resp(0, 5'd5, 32'h1122_3344, 32'hAABB_1122, 4'b0011);

        // Remaining extension modes and lane offsets, checked via the model
        issue(32'hBFC0_0010, 1'b1, 5'd6, 32'h3000_0003, 3'd2, 32'h0, 32'h80FF_0000, 1'b1);
        load_resp(2, 5'd6, 32'h80FF_0000, 32'h0000_0080, 4'hF);
        issue(32'hBFC0_0014, 1'b1, 5'd7, 32'h3000_0002, 3'd3, 32'h0, 32'h8001_7FFF, 1'b1);
        load_resp(0, 5'd7, 32'h8001_7FFF, 32'hFFFF_8001, 4'hF);
        issue(32'hBFC0_0018, 1'b1, 5'd8, 32'h3000_0000, 3'd4, 32'h0, 32'h8001_F00D, 1'b1);
        load_resp(1, 5'd8, 32'h8001_F00D, 32'h0000_F00D, 4'hF);
        issue(32'hBFC0_001C, 1'b1, 5'd10, 32'h3000_0000, 3'd5, 32'h0, 32'hDEAD_BEEF, 1'b1);
        load_resp(0, 5'd10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF);
        issue(32'hBFC0_0020, 1'b1, 5'd11, 32'h3000_0000, 3'd6, 32'h0102_0304, 32'hA0B0_C0D0, 1'b1);
        load_resp(0, 5'd11, 32'hA0B0_C0D0, 32'hD002_0304, 4'b1000);
        issue(32'hBFC0_0024, 1'b1, 5'd12, 32'h3000_0003, 3'd7, 32'h0102_0304, 32'hA0B0_C0D0, 1'b1);
        load_resp(0, 5'd12, 32'hA0B0_C0D0, 32'h0102_03A0, 4'b0001);

        // 4: back-to-back ALU stream
        for (int i = 0; i < 4; i++) begin
            issue(32'hBFC0_0100 + 32'(4 * i), 1'b1, 5'(13 + i),
                  32'hCAFE_0000 + 32'(i), 3'd0, 32'h0, 32'h0, 1'b1);
        end
        @(negedge clk);
        check("stream_last_we", rf_we, 1);
        idle(1);
        check("stream_drained", sb.size(), 0);

        // 5: dest=0 never writes; stray data_ok in IDLE ignored
        issue(32'hBFC0_0200, 1'b1, 5'd0, 32'h5555_5555, 3'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("d0_we", rf_we, 0);
        check("d0_fwdv", ws_fwd_valid, 0);
        idle(1);
        data_data_ok = 1'b1;
        data_rdata   = 32'h7777_7777;
        @(negedge clk);
        check("stray_we", rf_we, 0);
        check("stray_allowin", ws_allowin, 1);
        idle(1);
        data_data_ok = 1'b0;

        // 6: reset during WAIT drops the load
        issue(32'hBFC0_0300, 1'b1, 5'd20, 32'h4000_0000, 3'd5, 32'h0, 32'h1357_9BDF, 1'b0);
        @(negedge clk);
        check("w6_blocked", ws_fwd_blocked, 1);
        #1 resetn = 1'b0;
        #1 check_reset_outputs("arst");
        @(posedge clk); #1;
        resetn = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h1357_9BDF;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_we", rf_we, 0);
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        idle(2);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
